// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline hazard and sequencing controller for the 5-stage RV32 core.
// Produces stall/flush controls for the PC, IF/ID and ID/EX registers from
// load-use hazards, taken-branch redirects and multi-cycle EX operations.
// All control outputs are combinational from the state and the current inputs.
// Optional performance counters are built only when HAZARD_PERF_EN is defined;
// otherwise the counter outputs are tied to zero.
module hazard_ctrl #(
    parameter int REDIRECT_LAT = 1,   // extra ifid_flush cycles after a redirect (0..15)
    parameter int CNT_W        = 32   // performance counter width
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_use_rs1,
    input  logic             id_use_rs2,
    input  logic             ex_mem_read,
    input  logic [4:0]       ex_rd,
    input  logic             ex_branch_taken,
    input  logic             ex_mc_valid,
    input  logic             mc_done,
    output logic             pc_stall,
    output logic             ifid_stall,
    output logic             ifid_flush,
    output logic             idex_bubble,
    output logic             ex_hold,
    output logic             mc_go,
    output logic [CNT_W-1:0] load_use_cnt,
    output logic [CNT_W-1:0] flush_cnt,
    output logic [CNT_W-1:0] mc_stall_cnt
);

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        FLUSH   = 2'd1,
        MC_WAIT = 2'd2
    } state_t;

    state_t     state;
    state_t     state_nxt;
    logic [3:0] fcnt;
    logic [3:0] fcnt_nxt;
    logic       lu;

    // Load-use hazard: a load in EX writes a register the ID instruction reads.
    always_comb begin
        lu = ex_mem_read && (ex_rd != 5'd0) &&
             ((id_use_rs1 && (id_rs1 == ex_rd)) ||
              (id_use_rs2 && (id_rs2 == ex_rd)));
    end

    // State and flush-window down-counter register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= RUN;
            fcnt  <= 4'd0;
        end else begin
            state <= state_nxt;
            fcnt  <= fcnt_nxt;
        end
    end

    // Next-state and output decode; everything is forced low while reset is held.
    always_comb begin
        state_nxt   = state;
        fcnt_nxt    = fcnt;
        pc_stall    = 1'b0;
        ifid_stall  = 1'b0;
        ifid_flush  = 1'b0;
        idex_bubble = 1'b0;
        ex_hold     = 1'b0;
        mc_go       = 1'b0;

        if (!reset) begin
            unique case (state)
                RUN: begin
                    if (ex_branch_taken) begin
                        // Redirect wins over everything; the ID instruction is wrong-path.
                        ifid_flush  = 1'b1;
                        idex_bubble = 1'b1;
                        if (REDIRECT_LAT > 0) begin
                            state_nxt = FLUSH;
                            fcnt_nxt  = 4'(REDIRECT_LAT);
                        end
                    end else if (ex_mc_valid) begin
                        // Launch the multi-cycle unit; a done seen this cycle is stale.
                        mc_go      = 1'b1;
                        pc_stall   = 1'b1;
                        ifid_stall = 1'b1;
                        ex_hold    = 1'b1;
                        state_nxt  = MC_WAIT;
                    end else if (lu) begin
                        // One bubble lets the load reach MEM, after which LU clears.
                        pc_stall    = 1'b1;
                        ifid_stall  = 1'b1;
                        idex_bubble = 1'b1;
                    end
                end

                FLUSH: begin
                    // ID holds a NOP, so hazards and multi-cycle requests are ignored,
                    // as is an (illegal) further taken branch.
                    ifid_flush = 1'b1;
                    if (fcnt <= 4'd1) begin
                        state_nxt = RUN;
                        fcnt_nxt  = 4'd0;
                    end else begin
                        fcnt_nxt = fcnt - 4'd1;
                    end
                end

                MC_WAIT: begin
                    if (mc_done) begin
                        // Release in the done cycle so the result moves on immediately.
                        state_nxt = RUN;
                    end else begin
                        pc_stall   = 1'b1;
                        ifid_stall = 1'b1;
                        ex_hold    = 1'b1;
                    end
                end

                default: begin
                    state_nxt = RUN;
                    fcnt_nxt  = 4'd0;
                end
            endcase
        end
    end

`ifdef HAZARD_PERF_EN
    logic [CNT_W-1:0] lu_cnt_q;
    logic [CNT_W-1:0] fl_cnt_q;
    logic [CNT_W-1:0] mc_cnt_q;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        if (&v) begin
            return v;
        end
        return v + {{(CNT_W-1){1'b0}}, 1'b1};
    endfunction

    // Event counters. A bubble with a stall is only produced by the LU case,
    // and a bubble with a flush only by an accepted redirect.
    always_ff @(posedge clk) begin
        if (reset) begin
            lu_cnt_q <= '0;
            fl_cnt_q <= '0;
            mc_cnt_q <= '0;
        end else begin
            if (idex_bubble && ifid_stall) begin
                lu_cnt_q <= sat_inc(lu_cnt_q);
            end
            if (idex_bubble && ifid_flush) begin
                fl_cnt_q <= sat_inc(fl_cnt_q);
            end
            if (ex_hold) begin
                mc_cnt_q <= sat_inc(mc_cnt_q);
            end
        end
    end

    assign load_use_cnt = lu_cnt_q;
    assign flush_cnt    = fl_cnt_q;
    assign mc_stall_cnt = mc_cnt_q;
`else
    assign load_use_cnt = '0;
    assign flush_cnt    = '0;
    assign mc_stall_cnt = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed bench for hazard_ctrl. Two instances share one set
// of inputs: REDIRECT_LAT=1 (suffix 1) and REDIRECT_LAT=0 (suffix 0).
// Output vectors are packed {pc_stall, ifid_stall, ifid_flush, idex_bubble, ex_hold, mc_go}.
module tb_hazard_ctrl;

`ifdef HAZARD_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    localparam logic [5:0] IDLE = 6'b000000;
    localparam logic [5:0] LUS  = 6'b110100;
    localparam logic [5:0] BR   = 6'b001100;
    localparam logic [5:0] FL   = 6'b001000;
    localparam logic [5:0] GO   = 6'b110011;
    localparam logic [5:0] WT   = 6'b110010;

    logic       clk;
    logic       reset;
    logic [4:0] id_rs1, id_rs2, ex_rd;
    logic       id_use_rs1, id_use_rs2, ex_mem_read;
    logic       ex_branch_taken, ex_mc_valid, mc_done;

    logic        pc_stall1, ifid_stall1, ifid_flush1, idex_bubble1, ex_hold1, mc_go1;
    logic        pc_stall0, ifid_stall0, ifid_flush0, idex_bubble0, ex_hold0, mc_go0;
    logic [31:0] lu_cnt1, fl_cnt1, mc_cnt1;
    logic [31:0] lu_cnt0, fl_cnt0, mc_cnt0;
    logic [5:0]  o1, o0;

    int n_tests = 0;
    int n_fail  = 0;

    hazard_ctrl #(.REDIRECT_LAT(1), .CNT_W(32)) dut1 (
        .clk(clk), .reset(reset),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
        .ex_mem_read(ex_mem_read), .ex_rd(ex_rd), .ex_branch_taken(ex_branch_taken),
        .ex_mc_valid(ex_mc_valid), .mc_done(mc_done),
        .pc_stall(pc_stall1), .ifid_stall(ifid_stall1), .ifid_flush(ifid_flush1),
        .idex_bubble(idex_bubble1), .ex_hold(ex_hold1), .mc_go(mc_go1),
        .load_use_cnt(lu_cnt1), .flush_cnt(fl_cnt1), .mc_stall_cnt(mc_cnt1)
    );

    hazard_ctrl #(.REDIRECT_LAT(0), .CNT_W(32)) dut0 (
        .clk(clk), .reset(reset),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
        .ex_mem_read(ex_mem_read), .ex_rd(ex_rd), .ex_branch_taken(ex_branch_taken),
        .ex_mc_valid(ex_mc_valid), .mc_done(mc_done),
        .pc_stall(pc_stall0), .ifid_stall(ifid_stall0), .ifid_flush(ifid_flush0),
        .idex_bubble(idex_bubble0), .ex_hold(ex_hold0), .mc_go(mc_go0),
        .load_use_cnt(lu_cnt0), .flush_cnt(fl_cnt0), .mc_stall_cnt(mc_cnt0)
    );

    assign o1 = {pc_stall1, ifid_stall1, ifid_flush1, idex_bubble1, ex_hold1, mc_go1};
    assign o0 = {pc_stall0, ifid_stall0, ifid_flush0, idex_bubble0, ex_hold0, mc_go0};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] cexp(input int n);
        return PERF ? 32'(n) : 32'd0;
    endfunction

    task automatic chk6(input string tag, input logic [5:0] got, input logic [5:0] exp);
        n_tests++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%b expected=%b", tag, got, exp);
        end
    endtask

    task automatic chkc(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
        end
    endtask

    task automatic drive(input logic br, input logic mcv, input logic mcd,
                         input logic mr, input logic [4:0] rd,
                         input logic [4:0] rs1, input logic u1,
                         input logic [4:0] rs2, input logic u2);
        ex_branch_taken = br;
        ex_mc_valid     = mcv;
        mc_done         = mcd;
        ex_mem_read     = mr;
        ex_rd           = rd;
        id_rs1          = rs1;
        id_use_rs1      = u1;
        id_rs2          = rs2;
        id_use_rs2      = u2;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0);
    endtask

    // Inputs are driven at a falling edge; outputs are sampled 1 time unit later
    // and the task returns on the next falling edge (one rising edge consumed).
    task automatic step(input string tag, input logic [5:0] e1, input logic [5:0] e0);
        #1;
        chk6({tag, "/lat1"}, o1, e1);
        chk6({tag, "/lat0"}, o0, e0);
        @(negedge clk);
    endtask

    task automatic chk_all(input string tag, input int l1, input int f1, input int m1,
                           input int l0, input int f0, input int m0);
        chkc({tag, "/lu_cnt1"}, lu_cnt1, cexp(l1));
        chkc({tag, "/fl_cnt1"}, fl_cnt1, cexp(f1));
        chkc({tag, "/mc_cnt1"}, mc_cnt1, cexp(m1));
        chkc({tag, "/lu_cnt0"}, lu_cnt0, cexp(l0));
        chkc({tag, "/fl_cnt0"}, fl_cnt0, cexp(f0));
        chkc({tag, "/mc_cnt0"}, mc_cnt0, cexp(m0));
    endtask

    initial begin
        reset = 1'b1;
        drive(1'b1, 1'b1, 1'b0, 1'b1, 5'd5, 5'd5, 1'b1, 5'd0, 1'b0);
        @(negedge clk);
        // Reset cycle: hazardous inputs present, all outputs must stay low.
        step("reset_outputs", IDLE, IDLE);
        chk_all("reset_cnt", 0, 0, 0, 0, 0, 0);
        reset = 1'b0;

        idle();
        step("idle", IDLE, IDLE);

        // Load-use on rs1: exactly one stall cycle.
        drive(1'b0, 1'b0, 1'b0, 1'b1, 5'd5, 5'd5, 1'b1, 5'd0, 1'b0);
        step("lu_rs1", LUS, LUS);
        idle();
        step("lu_cleared", IDLE, IDLE);
        drive(1'b0, 1'b0, 1'b0, 1'b1, 5'd0, 5'd0, 1'b1, 5'd0, 1'b0);
        step("lu_rd0", IDLE, IDLE);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 5'd5, 5'd5, 1'b1, 5'd0, 1'b0);
        step("lu_not_load", IDLE, IDLE);
        drive(1'b0, 1'b0, 1'b0, 1'b1, 5'd7, 5'd3, 1'b1, 5'd7, 1'b1);
        step("lu_rs2", LUS, LUS);
        drive(1'b0, 1'b0, 1'b0, 1'b1, 5'd7, 5'd7, 1'b0, 5'd7, 1'b0);
        step("lu_unused_regs", IDLE, IDLE);
        chk_all("after_lu", 2, 0, 0, 2, 0, 0);

        // Taken branch: two-cycle flush with LAT=1, LU ignored in FLUSH.
        drive(1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0);
        step("br_first", BR, BR);
        drive(1'b0, 1'b0, 1'b0, 1'b1, 5'd5, 5'd5, 1'b1, 5'd0, 1'b0);
        step("br_flush_lu", FL, LUS);
        idle();
        step("br_done", IDLE, IDLE);
        chk_all("after_br", 2, 1, 0, 3, 1, 0);

        // Branch and load-use together: flush wins, no load-use count.
        drive(1'b1, 1'b0, 1'b0, 1'b1, 5'd9, 5'd9, 1'b1, 5'd9, 1'b1);
        step("br_lu", BR, BR);
        idle();
        step("br_lu_flush", FL, IDLE);
        step("br_lu_done", IDLE, IDLE);
        chk_all("after_br_lu", 2, 2, 0, 3, 2, 0);

        // Multi-cycle op: done in the go cycle is ignored; done 4 cycles later releases.
        drive(1'b0, 1'b1, 1'b1, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0);
        step("mc_go", GO, GO);
        drive(1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0);
        step("mc_wait1", WT, WT);
        drive(1'b0, 1'b1, 1'b0, 1'b1, 5'd4, 5'd4, 1'b1, 5'd0, 1'b0);
        step("mc_wait2_lu", WT, WT);
        drive(1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0);
        step("mc_wait3", WT, WT);
        drive(1'b0, 1'b1, 1'b1, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0);
        step("mc_done", IDLE, IDLE);
        idle();
        step("mc_after", IDLE, IDLE);
        chk_all("after_mc", 2, 2, 4, 3, 2, 4);

        // Reset on the second wait cycle aborts the operation.
        drive(1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0);
        step("mcr_go", GO, GO);
        step("mcr_wait1", WT, WT);
        reset = 1'b1;
        step("mcr_reset", IDLE, IDLE);
        reset = 1'b0;
        idle();
        chk_all("mcr_cnt", 0, 0, 0, 0, 0, 0);
        step("mcr_run", IDLE, IDLE);
        step("mcr_run2", IDLE, IDLE);

        // Back-to-back taken branches three cycles apart.
        drive(1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0);
        step("sw_br1", BR, BR);
        idle();
        step("sw_gap1", FL, IDLE);
        step("sw_gap2", IDLE, IDLE);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0);
        step("sw_br2", BR, BR);
        chk_all("sweep_cnt", 0, 2, 0, 0, 2, 0);
        // A taken branch during FLUSH is ignored by the LAT=1 instance.
        step("sw_br_in_flush", FL, BR);
        idle();
        step("sw_end", IDLE, IDLE);
        chk_all("illegal_br_cnt", 0, 2, 0, 0, 3, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Central pipeline hazard and sequencing controller for the 5-stage RV32 core.
- Drives the stall and flush controls of the PC register, the IF/ID register and the ID/EX register.
- Handles three cases: load-use hazards, taken-branch redirects (with a programmable fetch-latency flush window) and multi-cycle EX operations (go/done handshake).
- Sits beside the decode stage. Inputs come from decode and EX; outputs fan out to PC, IF/ID and ID/EX.

Parameters:
- REDIRECT_LAT, 1, number of extra cycles `ifid_flush` is held after a taken branch, covering instruction-memory latency (0..15).
- CNT_W, 32, width of the performance counters (optional feature only).

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous active-high reset
- id_rs1  in  5  rs1 index of the instruction in ID
- id_rs2  in  5  rs2 index of the instruction in ID
- id_use_rs1  in  1  ID instruction reads rs1
- id_use_rs2  in  1  ID instruction reads rs2
- ex_mem_read  in  1  instruction in EX is a load
- ex_rd  in  5  destination register of the instruction in EX
- ex_branch_taken  in  1  EX resolved a taken branch or jalr this cycle
- ex_mc_valid  in  1  EX holds a multi-cycle op (mul/div)
- mc_done  in  1  multi-cycle unit result valid (single-cycle pulse)
- pc_stall  out  1  hold the PC
- ifid_stall  out  1  stall input of the IF/ID register
- ifid_flush  out  1  flush input of the IF/ID register (inserts NOP 0x00000013)
- idex_bubble  out  1  load a NOP into ID/EX
- ex_hold  out  1  freeze ID/EX and the EX-stage operands
- mc_go  out  1  start pulse to the multi-cycle unit
- load_use_cnt  out  CNT_W  load-use stall counter
- flush_cnt  out  CNT_W  redirect counter
- mc_stall_cnt  out  CNT_W  multi-cycle stall cycle counter

Behaviour:
- Architecture: FSM with states RUN, FLUSH and MC_WAIT, plus a 4-bit down-counter `fcnt`. All outputs are combinational from the state and the current inputs; only the state, `fcnt` and the counters are registered.
- Reset: state=RUN, fcnt=0, counters=0. During the reset cycle all outputs are 0. A reset asserted mid-FLUSH or mid-MC_WAIT aborts immediately; no `mc_go` is reissued.
- Load-use hazard (LU) is defined as: ex_mem_read && ex_rd!=0 && ((id_use_rs1 && id_rs1==ex_rd) || (id_use_rs2 && id_rs2==ex_rd)).
- RUN, priority order (highest first):
  1. ex_branch_taken: ifid_flush=1 and idex_bubble=1; LU is ignored. If REDIRECT_LAT>0, go to FLUSH with fcnt=REDIRECT_LAT; otherwise stay in RUN.
  2. ex_mc_valid: mc_go=1, pc_stall=1, ifid_stall=1, ex_hold=1; go to MC_WAIT. If mc_done is already asserted in the same cycle, it is ignored.
  3. LU: pc_stall=1, ifid_stall=1, idex_bubble=1 for exactly one cycle; stay in RUN. The load advances to MEM, so LU clears on the next cycle.
  4. Otherwise all outputs are 0.
- FLUSH:
  - ifid_flush=1; idex_bubble=0; LU and ex_mc_valid are ignored (ID holds a NOP).
  - fcnt decrements each cycle; when fcnt==1, return to RUN.
  - Total flush length is exactly 1+REDIRECT_LAT consecutive cycles.
  - ex_branch_taken in FLUSH cannot legally occur. If it does, it is ignored and no counter increments.
- MC_WAIT:
  - pc_stall=1, ifid_stall=1, ex_hold=1; mc_go=0; LU is ignored.
  - On mc_done: all holds are released in that same cycle (outputs 0), and the state returns to RUN on the next edge.
  - No timeout is applied.
- Multi-cycle stall length: stall cycles = 1 (the mc_go cycle) + the number of MC_WAIT cycles before and including the mc_done cycle, minus that cycle's release.
- Invariant: ifid_flush and ifid_stall are never asserted together. pc_stall is always equal to ifid_stall.

Optional Feature:
- Macro: HAZARD_PERF_EN.
- Defined:
  - load_use_cnt increments on every cycle in which the LU stall is applied.
  - flush_cnt increments once per accepted taken branch.
  - mc_stall_cnt increments on every cycle with ex_hold=1.
  - All three saturate at all-ones and clear on reset.
- Undefined: the three counter outputs are tied to 0 and no counter flops are synthesized.

Test Plan:
- Load-use: ex_mem_read=1, ex_rd=5, id_rs1=5, id_use_rs1=1 for one cycle → pc_stall=ifid_stall=idex_bubble=1 for exactly 1 cycle. With ex_rd=0 instead → no stall.
- Branch, REDIRECT_LAT=1: ex_branch_taken pulse → ifid_flush=1 for 2 consecutive cycles; idex_bubble=1 only in the first; flush_cnt=1.
- Branch and LU in the same cycle → flush wins: ifid_stall=0, idex_bubble=1, load_use_cnt unchanged.
- Multi-cycle op: ex_mc_valid=1, mc_done pulses 4 cycles later → mc_go is a 1-cycle pulse; ex_hold=1 for 4 cycles, released in the mc_done cycle; mc_stall_cnt=4.
- Reset mid-MC_WAIT: assert reset on the 2nd wait cycle → the next cycle shows state RUN, all outputs 0, counters 0, no second mc_go.
- REDIRECT_LAT=0 sweep: back-to-back taken branches 3 cycles apart → each produces exactly a 1-cycle flush; flush_cnt=2.
